// File: rtl/fast_square_tx_if.sv
// Settings bus, sweep control and I/Q/handshake outputs of the fast-square transmitter.
interface fast_square_tx_if;
    logic        [6:0]  serial_addr;
    logic        [31:0] serial_data;
    logic               serial_strobe;
    logic               start;
    logic               stop;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               record;
    logic               freq_step;
    logic               busy;
    logic               done;

    modport master (
        output serial_addr, serial_data, serial_strobe, start, stop,
        input  i_out, q_out, record, freq_step, busy, done
    );

    modport slave (
        input  serial_addr, serial_data, serial_strobe, start, stop,
        output i_out, q_out, record, freq_step, busy, done
    );
endinterface

// File: rtl/fast_square_tx.sv
// Four-tone square-wave I/Q sweep generator. Tones sit at {-3f, -f, +f, +3f} and are stepped
// after every dwell with the same arithmetic the fast-square receiver uses.
module fast_square_tx #(
    parameter logic [6:0]  SubcarrierFreqAddr = 7'd1,
    parameter logic [6:0]  DwellAddr          = 7'd3,
    parameter logic [6:0]  CtrlAddr           = 7'd4,
    parameter logic [6:0]  AmpAddr            = 7'd5,
    parameter int unsigned NumSubcarriers     = 4
) (
    input logic               clock_i,
    input logic               reset_i,
    fast_square_tx_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StDwell, StGap} state_e;

    // Settings-bus shadow registers (deliberately not reset)
    logic [31:0] sub_freq_set_q;
    logic [15:0] dwell_set_q;
    logic [15:0] gap_set_q;
    logic [7:0]  steps_set_q;
    logic        cont_set_q;
    logic [12:0] amp_set_q;

    // Working copies captured at start
    logic [31:0] base_q;
    logic [15:0] dwell_last_q;
    logic [15:0] gap_last_q;
    logic [7:0]  step_last_q;
    logic        cont_q;
    logic [12:0] amp_q;
    logic [31:0] step_small_q;
    logic [31:0] step_large_q;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         step_ctr_q, step_ctr_d;
    logic [31:0]        freq_q  [NumSubcarriers];
    logic [31:0]        freq_d  [NumSubcarriers];
    logic [31:0]        phase_q [NumSubcarriers];
    logic [31:0]        phase_d [NumSubcarriers];
    logic signed [15:0] i_out_q, i_out_d;
    logic signed [15:0] q_out_q, q_out_d;
    logic               done_q, done_d;

    logic               start_acc;
    logic               load_base;
    logic               do_step;
    logic               freq_step;
    logic [31:0]        base_src;
    logic [31:0]        step_inc;
    logic signed [15:0] i_sum, q_sum;
    logic signed [15:0] amp_s;
    logic               unused_ctrl_bits;

    assign unused_ctrl_bits = ^bus.serial_data[30:24];

    // stop wins over start; start is only honoured from idle
    assign start_acc = bus.start && !bus.stop && (state_q == StIdle);

    // Settings bus writes
    always_ff @(posedge clock_i) begin
        if (bus.serial_strobe) begin
            if (bus.serial_addr == SubcarrierFreqAddr) sub_freq_set_q <= bus.serial_data;
            if (bus.serial_addr == DwellAddr)          dwell_set_q    <= bus.serial_data[15:0];
            if (bus.serial_addr == CtrlAddr) begin
                gap_set_q   <= bus.serial_data[15:0];
                steps_set_q <= bus.serial_data[23:16];
                cont_set_q  <= bus.serial_data[31];
            end
            if (bus.serial_addr == AmpAddr)            amp_set_q      <= bus.serial_data[12:0];
        end
    end

    // Snapshot settings on an accepted start; a same-cycle write is seen only by the next start
    always_ff @(posedge clock_i) begin
        if (start_acc) begin
            base_q       <= sub_freq_set_q;
            dwell_last_q <= (dwell_set_q == 16'd0) ? 16'd0 : dwell_set_q - 16'd1;
            gap_last_q   <= (gap_set_q == 16'd0) ? 16'd0 : gap_set_q - 16'd1;
            step_last_q  <= steps_set_q - 8'd1;  // 0 wraps to 255, i.e. 256 steps
            cont_q       <= cont_set_q;
            amp_q        <= amp_set_q;
            step_small_q <= 32'h8000_0000 - ((sub_freq_set_q << 2) + (sub_freq_set_q << 1));
            step_large_q <= 32'h8000_0000 - (sub_freq_set_q << 3);
        end
    end

    // Sweep FSM: next state, counters and handshake pulses
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_ctr_d = step_ctr_q;
        done_d     = 1'b0;
        load_base  = 1'b0;
        do_step    = 1'b0;
        freq_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d    = StDwell;
                    cnt_d      = 16'd0;
                    step_ctr_d = 8'd0;
                    load_base  = 1'b1;
                end
            end
            StDwell: begin
                if (cnt_q == dwell_last_q) begin
                    state_d = StGap;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == 16'd0) begin
                    freq_step = 1'b1;
                    do_step   = 1'b1;
                end
                if (cnt_q == gap_last_q) begin
                    cnt_d = 16'd0;
                    if (step_ctr_q == step_last_q) begin
                        if (cont_q) begin
                            load_base  = 1'b1;
                            step_ctr_d = 8'd0;
                            state_d    = StDwell;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        step_ctr_d = step_ctr_q + 8'd1;
                        state_d    = StDwell;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.stop) begin
            state_d    = StIdle;
            cnt_d      = 16'd0;
            step_ctr_d = 8'd0;
            done_d     = 1'b0;
            load_base  = 1'b0;
            do_step    = 1'b0;
            freq_step  = 1'b0;
        end
    end

    // Tone frequencies, phase accumulators and output sample
    always_comb begin
        base_src = (state_q == StIdle) ? sub_freq_set_q : base_q;
        step_inc = ($signed(freq_q[1]) > $signed(32'd0 - step_small_q)) ? step_large_q
                                                                          : step_small_q;
        for (int k = 0; k < NumSubcarriers; k++) begin
            freq_d[k] = freq_q[k];
            if (do_step) freq_d[k] = freq_q[k] + step_inc;
            // Phases advance only between dwell clocks, so every dwell starts from phase 0
            phase_d[k] = (state_q == StDwell && state_d == StDwell) ? phase_q[k] + freq_q[k]
                                                                    : 32'd0;
        end
        if (load_base) begin
            freq_d[0] = 32'd0 - ((base_src << 1) + base_src);
            freq_d[1] = 32'd0 - base_src;
            freq_d[2] = base_src;
            freq_d[3] = (base_src << 1) + base_src;
        end
        amp_s = $signed({3'b000, amp_q});
        i_sum = 16'sd0;
        q_sum = 16'sd0;
        for (int k = 0; k < NumSubcarriers; k++) begin
            i_sum = phase_q[k][31] ? i_sum - amp_s : i_sum + amp_s;
            q_sum = (phase_q[k][31] ^ phase_q[k][30]) ? q_sum - amp_s : q_sum + amp_s;
        end
        i_out_d = (state_q == StDwell && !bus.stop) ? i_sum : 16'sd0;
        q_out_d = (state_q == StDwell && !bus.stop) ? q_sum : 16'sd0;
    end

    // State register with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            step_ctr_q <= 8'd0;
            i_out_q    <= 16'sd0;
            q_out_q    <= 16'sd0;
            done_q     <= 1'b0;
            for (int k = 0; k < NumSubcarriers; k++) begin
                freq_q[k]  <= 32'd0;
                phase_q[k] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_ctr_q <= step_ctr_d;
            i_out_q    <= i_out_d;
            q_out_q    <= q_out_d;
            done_q     <= done_d;
            for (int k = 0; k < NumSubcarriers; k++) begin
                freq_q[k]  <= freq_d[k];
                phase_q[k] <= phase_d[k];
            end
        end
    end

    assign bus.i_out     = i_out_q;
    assign bus.q_out     = q_out_q;
    assign bus.record    = (state_q == StDwell);
    assign bus.busy      = (state_q != StIdle);
    assign bus.freq_step = freq_step;
    assign bus.done      = done_q;

endmodule
